tile_board_engine: RTL and testbench

- Writer side of the 16-bit 4x4 tile matrix that the VGA renderer reads. Holds the 2048-style game board and score.
- Executes one move command per handshake: slides and merges one line per cycle, spawns a new tile through an LFSR, then checks win and game-over.
- Commits the board atomically to the matriz output, which feeds the display path directly.

---
 rtl/tile_pkg.sv | 53 +++++
 rtl/tile_board_engine_line_merge.sv | 63 ++++++
 rtl/tile_board_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_tile_board_engine.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// tile_pkg: shared types and helpers for the 2048 tile board engine.
//   TILE_W / N   tile width and board dimension
//   board_t      4x4 board of 16-bit tiles, indexed [row][col]
//   line_t       one 4-tile line in slide order (index 0 = destination side)
//   dir_t        move direction encoding as seen on move_dir
//   state_t      engine FSM states
//   lfsr_next()  one step of the spawn LFSR
//   board_stuck() true when no empty cell and no equal orthogonal neighbours
package tile_pkg;

    localparam int TILE_W = 16;
    localparam int N      = 4;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [TILE_W-1:0] tile_t;
    typedef tile_t [0:N-1]     line_t;
    typedef line_t [0:N-1]     board_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LINE,
        ST_SPAWN,
        ST_CHECK
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic board_stuck(input board_t b);
        logic stuck;
        stuck = 1'b1;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (b[r][c] == '0) stuck = 1'b0;
                if (c < N-1 && b[r][c] == b[r][c+1]) stuck = 1'b0;
                if (r < N-1 && b[r][c] == b[r+1][c]) stuck = 1'b0;
            end
        end
        return stuck;
    endfunction

endpackage

// File: rtl/tile_board_engine_line_merge.sv
// line_merge: combinational slide-and-merge of one 4-tile line.
//   line_in    tiles in slide order (index 0 is where tiles slide towards)
//   line_out   compressed, merged, recompressed line
//   merge_sum  sum of the values created by merges in this line
//   changed    line_out differs from line_in
module line_merge
    import tile_pkg::*;
(
    input  line_t       line_in,
    output line_t       line_out,
    output logic [15:0] merge_sum,
    output logic        changed
);

    line_t       packed_l;
    line_t       merged_l;
    logic [2:0]  wr_a;
    logic [2:0]  wr_b;
    logic        skip;
    logic [16:0] pair_sum;

    always_comb begin
        packed_l  = '0;
        merged_l  = '0;
        line_out  = '0;
        merge_sum = '0;
        wr_a      = '0;
        wr_b      = '0;
        skip      = 1'b0;
        pair_sum  = '0;

        for (int i = 0; i < N; i++) begin
            if (line_in[i] != '0) begin
                packed_l[wr_a[1:0]] = line_in[i];
                wr_a = wr_a + 3'd1;
            end
        end

        // The skip after a merge keeps a freshly merged tile from merging again.
        merged_l = packed_l;
        for (int i = 0; i < N-1; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (merged_l[i] != '0 && merged_l[i] == merged_l[i+1]) begin
                pair_sum      = {1'b0, merged_l[i]} + {1'b0, merged_l[i+1]};
                merged_l[i]   = pair_sum[16] ? 16'hFFFF : pair_sum[15:0];
                merged_l[i+1] = '0;
                merge_sum     = merge_sum + merged_l[i];
                skip          = 1'b1;
            end
        end

        for (int i = 0; i < N; i++) begin
            if (merged_l[i] != '0) begin
                line_out[wr_b[1:0]] = merged_l[i];
                wr_b = wr_b + 3'd1;
            end
        end

        changed = (line_out != line_in);
    end

endmodule

// File: rtl/tile_board_engine.sv
// tile_board_engine: writer side of the 4x4 tile matrix read by the renderer.
//   clk, rst          clock, asynchronous active-low reset
//   move_valid/dir    move request (held until move_ready)
//   move_ready        engine accepts a move or load this cycle
//   load_valid        load board_in as the board
//   new_game          synchronous restart, overrides everything
//   matriz            committed board, updated only at CHECK or restart
//   score             cumulative merged value
//   done / moved      one-cycle completion pulse and board-changed flag
//   win / game_over   sticky win, no-moves-left status
module tile_board_engine
    import tile_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [15:0] WIN_VALUE = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    input  logic        load_valid,
    input  board_t      board_in,
    input  logic        new_game,
    output board_t      matriz,
    output logic [31:0] score,
    output logic        done,
    output logic        moved,
    output logic        win,
    output logic        game_over
);

    state_t      state_q, state_d;
    board_t      work_q, work_d;
    board_t      matriz_q, matriz_d;
    logic [31:0] score_q, score_d;
    logic        win_q, win_d;
    logic        go_q, go_d;
    logic        done_q, done_d;
    logic        moved_q, moved_d;
    logic        acc_q, acc_d;
    dir_t        dir_q, dir_d;
    logic [1:0]  line_q, line_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  sidx_q, sidx_d;
    logic [3:0]  scnt_q, scnt_d;
    logic        second_q, second_d;

    logic [1:0]  lr [0:N-1];
    logic [1:0]  lc [0:N-1];
    line_t       mline, mout;
    logic [15:0] msum;
    logic        mchg;
    tile_t       scell;
    logic        any_win;

    assign move_ready = (state_q == ST_IDLE) && !go_q;
    assign matriz     = matriz_q;
    assign score      = score_q;
    assign done       = done_q;
    assign moved      = moved_q;
    assign win        = win_q;
    assign game_over  = go_q;

    // Map slide position k of the current line to a board cell.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            lr[k] = line_q;
            lc[k] = 2'(k);
            case (dir_q)
                DIR_LEFT:  begin lr[k] = line_q;       lc[k] = 2'(k);     end
                DIR_RIGHT: begin lr[k] = line_q;       lc[k] = 2'(N-1-k); end
                DIR_UP:    begin lr[k] = 2'(k);        lc[k] = line_q;    end
                DIR_DOWN:  begin lr[k] = 2'(N-1-k);    lc[k] = line_q;    end
                default:   begin lr[k] = line_q;       lc[k] = 2'(k);     end
            endcase
            mline[k] = work_q[lr[k]][lc[k]];
        end
    end

    line_merge u_merge (
        .line_in   (mline),
        .line_out  (mout),
        .merge_sum (msum),
        .changed   (mchg)
    );

    assign scell = work_q[sidx_q[3:2]][sidx_q[1:0]];

    always_comb begin
        any_win = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (work_q[r][c] >= WIN_VALUE) any_win = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        matriz_d = matriz_q;
        score_d  = score_q;
        win_d    = win_q;
        go_d     = go_q;
        done_d   = 1'b0;
        moved_d  = moved_q;
        acc_d    = acc_q;
        dir_d    = dir_q;
        line_d   = line_q;
        lfsr_d   = lfsr_next(lfsr_q);
        sidx_d   = sidx_q;
        scnt_d   = scnt_q;
        second_d = second_q;

        case (state_q)
            ST_INIT: begin
                // Two spawns: the second is armed via second_q.
                work_d   = '0;
                acc_d    = 1'b1;
                sidx_d   = lfsr_q[3:0];
                scnt_d   = '0;
                second_d = 1'b1;
                state_d  = ST_SPAWN;
            end
            ST_IDLE: begin
                if (move_ready) begin
                    if (load_valid) begin
                        work_d  = board_in;
                        acc_d   = 1'b1;
                        state_d = ST_CHECK;
                    end else if (move_valid) begin
                        dir_d   = dir_t'(move_dir);
                        line_d  = '0;
                        acc_d   = 1'b0;
                        state_d = ST_LINE;
                    end
                end
            end
            ST_LINE: begin
                for (int k = 0; k < N; k++)
                    work_d[lr[k]][lc[k]] = mout[k];
                score_d = score_q + {16'h0000, msum};
                acc_d   = acc_q | mchg;
                line_d  = line_q + 2'd1;
                if (line_q == 2'd3) begin
                    if (acc_q | mchg) begin
                        sidx_d   = lfsr_q[3:0];
                        scnt_d   = '0;
                        second_d = 1'b0;
                        state_d  = ST_SPAWN;
                    end else begin
                        state_d  = ST_CHECK;
                    end
                end
            end
            ST_SPAWN: begin
                if (scell == '0) begin
                    work_d[sidx_q[3:2]][sidx_q[1:0]] =
                        (lfsr_q[7:4] == 4'd0) ? 16'h0004 : 16'h0002;
                    if (second_q) begin
                        second_d = 1'b0;
                        sidx_d   = lfsr_q[3:0];
                        scnt_d   = '0;
                    end else begin
                        state_d  = ST_CHECK;
                    end
                end else begin
                    sidx_d = sidx_q + 4'd1;
                    scnt_d = scnt_q + 4'd1;
                    // Full board: give up after one full lap.
                    if (scnt_q == 4'd15) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                matriz_d = work_q;
                win_d    = win_q | any_win;
                go_d     = board_stuck(work_q);
                done_d   = 1'b1;
                moved_d  = acc_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase

        if (new_game) begin
            work_d   = '0;
            matriz_d = '0;
            score_d  = '0;
            win_d    = 1'b0;
            go_d     = 1'b0;
            acc_d    = 1'b0;
            done_d   = 1'b0;
            state_d  = ST_INIT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            work_q   <= '0;
            matriz_q <= '0;
            score_q  <= '0;
            win_q    <= 1'b0;
            go_q     <= 1'b0;
            done_q   <= 1'b0;
            moved_q  <= 1'b0;
            acc_q    <= 1'b0;
            dir_q    <= DIR_UP;
            line_q   <= '0;
            lfsr_q   <= LFSR_SEED;
            sidx_q   <= '0;
            scnt_q   <= '0;
            second_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            matriz_q <= matriz_d;
            score_q  <= score_d;
            win_q    <= win_d;
            go_q     <= go_d;
            done_q   <= done_d;
            moved_q  <= moved_d;
            acc_q    <= acc_d;
            dir_q    <= dir_d;
            line_q   <= line_d;
            lfsr_q   <= lfsr_d;
            sidx_q   <= sidx_d;
            scnt_q   <= scnt_d;
            second_q <= second_d;
        end
    end

endmodule

// File: tb/tb_tile_board_engine.sv
// Directed bench for tile_board_engine with a scoreboard of expected
// completions; each done pulse pops one entry and compares it.
module tb_tile_board_engine;
    import tile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic        load_valid;
    board_t      board_in;
    logic        new_game;
    board_t      matriz;
    logic [31:0] score;
    logic        done, moved, win, game_over;

    tile_board_engine dut (
        .clk        (clk),
        .rst        (rst),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_ready (move_ready),
        .load_valid (load_valid),
        .board_in   (board_in),
        .new_game   (new_game),
        .matriz     (matriz),
        .score      (score),
        .done       (done),
        .moved      (moved),
        .win        (win),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    // mode: 0 exact board, 1 exact plus one spawned tile, 2 fresh two-tile board
    typedef struct {
        board_t      board;
        logic [31:0] score;
        logic        moved;
        logic        win;
        logic        go;
        int          mode;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_score = 0;
    logic        exp_win   = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic board_t mk_row0(input tile_t a, input tile_t b, input tile_t c, input tile_t d);
        board_t x;
        x = '0;
        x[0][0] = a; x[0][1] = b; x[0][2] = c; x[0][3] = d;
        return x;
    endfunction

    task automatic wait_done(input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (done === 1'b1) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic compare_out(input string tag, input int cyc);
        exp_t e;
        int   nd, bad;
        check({tag, "_done_seen"}, 256'(cyc > 0), 256'(1));
        check({tag, "_sb_nonempty"}, 256'(sb.size() > 0), 256'(1));
        if (cyc <= 0 || sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "_moved"}, 256'(moved), 256'(e.moved));
        check({tag, "_score"}, 256'(score), 256'(e.score));
        check({tag, "_win"},   256'(win),   256'(e.win));
        check({tag, "_go"},    256'(game_over), 256'(e.go));
        nd = 0;
        bad = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (e.mode == 2) begin
                    if (matriz[r][c] != '0) begin
                        nd++;
                        if (!(matriz[r][c] == 16'h2 || matriz[r][c] == 16'h4)) bad++;
                    end
                end else if (matriz[r][c] !== e.board[r][c]) begin
                    nd++;
                    if (e.board[r][c] != '0 || !(matriz[r][c] == 16'h2 || matriz[r][c] == 16'h4)) bad++;
                end
            end
        end
        if (e.mode == 0) begin
            check({tag, "_board"}, matriz, e.board);
        end else begin
            check({tag, "_tiles"}, 256'(nd), (e.mode == 2) ? 256'(2) : 256'(1));
            check({tag, "_tileval"}, 256'(bad), 256'(0));
        end
    endtask

    task automatic do_load(input string tag, input board_t b, input logic go);
        exp_t e;
        int   cyc;
        check({tag, "_ready"}, 256'(move_ready), 256'(1));
        load_valid = 1'b1;
        board_in   = b;
        step();
        load_valid = 1'b0;
        e = '{board: b, score: exp_score, moved: 1'b1, win: exp_win, go: go, mode: 0};
        sb.push_back(e);
        wait_done(40, cyc);
        compare_out(tag, cyc);
    endtask

    task automatic do_move(input string tag, input dir_t d, input board_t exp_b,
                           input logic [31:0] add, input logic mv, input int lat);
        exp_t e;
        int   cyc;
        check({tag, "_ready"}, 256'(move_ready), 256'(1));
        move_valid = 1'b1;
        move_dir   = d;
        step();
        move_valid = 1'b0;
        exp_score  = exp_score + add;
        e = '{board: exp_b, score: exp_score, moved: mv, win: exp_win, go: 1'b0, mode: mv ? 1 : 0};
        sb.push_back(e);
        wait_done(40, cyc);
        compare_out(tag, cyc);
        if (lat > 0) check({tag, "_latency"}, 256'(cyc), 256'(lat));
    endtask

    task automatic do_new_game(input string tag);
        exp_t e;
        int   cyc;
        new_game = 1'b1;
        step();
        new_game  = 1'b0;
        exp_score = 0;
        exp_win   = 1'b0;
        check({tag, "_clr_board"}, matriz, '0);
        check({tag, "_clr_score"}, 256'(score), 256'(0));
        check({tag, "_clr_win"},   256'(win), 256'(0));
        check({tag, "_clr_done"},  256'(done), 256'(0));
        e = '{board: '0, score: 32'd0, moved: 1'b1, win: 1'b0, go: 1'b0, mode: 2};
        sb.push_back(e);
        wait_done(40, cyc);
        compare_out(tag, cyc);
    endtask

    initial begin
        board_t b;
        exp_t   e;
        int     dcnt;

        rst        = 1'b0;
        move_valid = 1'b0;
        move_dir   = 2'd0;
        load_valid = 1'b0;
        board_in   = '0;
        new_game   = 1'b0;
        repeat (3) step();

        check("rst_board", matriz, '0);
        check("rst_score", 256'(score), 256'(0));
        check("rst_done",  256'(done), 256'(0));
        check("rst_win",   256'(win), 256'(0));
        check("rst_go",    256'(game_over), 256'(0));
        check("rst_ready", 256'(move_ready), 256'(0));

        rst = 1'b1;
        e = '{board: '0, score: 32'd0, moved: 1'b1, win: 1'b0, go: 1'b0, mode: 2};
        sb.push_back(e);
        dcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (done === 1'b1) begin
                dcnt++;
                if (dcnt == 1) compare_out("init", i);
            end
        end
        check("init_done_count", 256'(dcnt), 256'(1));
        check("init_ready", 256'(move_ready), 256'(1));

        do_load("ld_a", mk_row0(16'h2, 16'h2, 16'h2, 16'h2), 1'b0);
        do_move("mv_left", DIR_LEFT, mk_row0(16'h4, 16'h4, 16'h0, 16'h0), 32'd8, 1'b1, 0);

        do_load("ld_b", mk_row0(16'h2, 16'h2, 16'h4, 16'h0), 1'b0);
        do_move("mv_right", DIR_RIGHT, mk_row0(16'h0, 16'h0, 16'h4, 16'h4), 32'd4, 1'b1, 0);

        do_load("ld_nm", mk_row0(16'h2, 16'h4, 16'h0, 16'h0), 1'b0);
        do_move("mv_none", DIR_LEFT, mk_row0(16'h2, 16'h4, 16'h0, 16'h0), 32'd0, 1'b0, 5);

        b = '0;
        b[0][0] = 16'h2; b[1][0] = 16'h2; b[2][0] = 16'h4; b[3][0] = 16'h4;
        do_load("ld_col", b, 1'b0);
        b = '0;
        b[3][0] = 16'h8; b[2][0] = 16'h4;
        do_move("mv_down", DIR_DOWN, b, 32'd12, 1'b1, 0);

        b = '0;
        b[1][1] = 16'h2; b[3][1] = 16'h2;
        do_load("ld_up", b, 1'b0);
        b = '0;
        b[0][1] = 16'h4;
        do_move("mv_up", DIR_UP, b, 32'd4, 1'b1, 0);

        do_load("ld_win", mk_row0(16'h400, 16'h400, 16'h0, 16'h0), 1'b0);
        exp_win = 1'b1;
        do_move("mv_win", DIR_LEFT, mk_row0(16'h800, 16'h0, 16'h0, 16'h0), 32'h800, 1'b1, 0);

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                b[r][c] = ((r + c) % 2 == 1) ? 16'h4 : 16'h2;
        do_load("ld_checker", b, 1'b1);
        check("go_ready", 256'(move_ready), 256'(0));
        move_valid = 1'b1;
        move_dir   = DIR_LEFT;
        step();
        move_valid = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) dcnt++;
            step();
        end
        check("go_no_done", 256'(dcnt), 256'(0));
        check("go_board_held", matriz, b);

        do_new_game("ng_go");

        b = mk_row0(16'h2, 16'h2, 16'h0, 16'h0);
        b[1][0] = 16'h4; b[1][1] = 16'h4;
        do_load("ld_abort", b, 1'b0);
        move_valid = 1'b1;
        move_dir   = DIR_LEFT;
        step();
        move_valid = 1'b0;
        step();
        check("abort_no_done1", 256'(done), 256'(0));
        do_new_game("ng_mid");
        check("final_sb_empty", 256'(sb.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
